// File: rtl/click_classifier.sv
// Classifies debounced button events into single or double clicks.
// A second rising edge inside the window is a double; otherwise a single.
module click_classifier #(
  parameter int WIN_BITS = 24,
  parameter int WINDOW   = 12_500_000
) (
  input  logic clk,
  input  logic i_sclr_n,
  input  logic i_bin,
  output logic o_single,
  output logic o_double,
  output logic o_busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [WIN_BITS-1:0] LAST = WIN_BITS'(WINDOW - 1);

  state_t              state_q, state_d;
  logic [WIN_BITS-1:0] cnt_q, cnt_d;
  logic                prev_q;
  logic                single_q, single_d;
  logic                double_q, double_d;
  logic                ev;

  // prev_q resets high so a button already held at reset release is not an event
  assign ev = i_bin & ~prev_q;

  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prev_q   <= 1'b1;
      single_q <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= i_bin;
      single_q <= single_d;
      double_q <= double_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // An edge on the last window cycle still counts as a double
        if (ev) begin
          double_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_single = single_q;
  assign o_double = double_q;
  assign o_busy   = (state_q == WAIT);

endmodule
